// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT output path.
// The typedefs describe a beat at the default sample/index widths; parameterised
// blocks use beat_width() to size a flat storage word for their own widths.
package fft_pkg;

    localparam int LANES      = 4;
    localparam int SAMPLES    = 2 * LANES;   // col1 lanes then col2 lanes
    localparam int PKG_DATA_W = 32;
    localparam int PKG_IDX_W  = 11;

    typedef struct packed {
        logic [PKG_DATA_W-1:0] re;
        logic [PKG_DATA_W-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic [PKG_IDX_W-1:0]    idx_col2;
        logic [PKG_IDX_W-1:0]    idx_col1;
        cplx_t [SAMPLES-1:0]     s;
    } beat_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_e;

    // Bits needed to hold one beat: 8 complex samples plus two column indices.
    function automatic int beat_width(input int data_w, input int idx_w);
        return SAMPLES * 2 * data_w + 2 * idx_w;
    endfunction

endpackage

// File: rtl/fft_out_serializer_beat_fifo.sv
// beat_fifo: synchronous FIFO of whole beats with full/empty/level.
// The storage array is not reset; only pointers and the level counter are.
// The caller guarantees push only when not full (or when popping in the same
// cycle) and pop only when not empty.
module beat_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;

    // Beat storage write; when full and popping, the write lands in the slot
    // being retired, whose old contents are still read out this cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop nets to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            level_reg <= level_reg + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign full      = (level_reg == (AW+1)'(DEPTH));
    assign empty     = (level_reg == '0);
    assign level     = level_reg;

endmodule

// File: rtl/fft_out_serializer.sv
// fft_out_serializer: buffers 8-sample beats from the recover stage and emits
// them one complex sample per cycle (col1 lanes 0..3, then col2 lanes 0..3)
// over a valid/ready interface. Beats that find no room are dropped and flagged.
// Optional build macro FFT_OUT_STATS_EN adds saturating beats_in/beats_dropped.
module fft_out_serializer
    import fft_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 11,
    parameter int DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    input  logic [LANES-1:0][DATA_W-1:0]    in_col1_r,
    input  logic [LANES-1:0][DATA_W-1:0]    in_col1_i,
    input  logic [LANES-1:0][DATA_W-1:0]    in_col2_r,
    input  logic [LANES-1:0][DATA_W-1:0]    in_col2_i,
    input  logic [IDX_W-1:0]                in_index_col1,
    input  logic [IDX_W-1:0]                in_index_col2,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_r,
    output logic [DATA_W-1:0]               out_i,
    output logic [IDX_W-1:0]                out_index,
    output logic                            out_col,
    output logic [1:0]                      out_lane,
    output logic [$clog2(DEPTH):0]          level,
    output logic                            overflow,
    input  logic                            clr_ovf
`ifdef FFT_OUT_STATS_EN
    ,
    output logic [15:0]                     beats_in,
    output logic [15:0]                     beats_dropped
`endif
);

    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int BEAT_W = beat_width(DATA_W, IDX_W);
    localparam int IDX_LO = SAMPLES * 2 * DATA_W;

    ser_state_e        state_reg;
    ser_state_e        state_next;
    logic [2:0]        cnt_reg;
    logic              overflow_reg;

    logic [BEAT_W-1:0] push_flat;
    logic [BEAT_W-1:0] head_flat;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LW-1:0]     fifo_level;

    logic              xfer;
    logic              last_xfer;
    logic              push;
    logic              drop;
    logic              stream;

    logic [DATA_W-1:0] samp_r [SAMPLES];
    logic [DATA_W-1:0] samp_i [SAMPLES];
    logic [IDX_W-1:0]  head_idx1;
    logic [IDX_W-1:0]  head_idx2;

    // Flatten the incoming beat: sample k = col1 lane k for k<4, col2 lane k-4 otherwise.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_pack
        assign push_flat[(2*gi)*DATA_W           +: DATA_W] = in_col1_r[gi];
        assign push_flat[(2*gi+1)*DATA_W         +: DATA_W] = in_col1_i[gi];
        assign push_flat[(2*(gi+LANES))*DATA_W   +: DATA_W] = in_col2_r[gi];
        assign push_flat[(2*(gi+LANES)+1)*DATA_W +: DATA_W] = in_col2_i[gi];
    end
    assign push_flat[IDX_LO         +: IDX_W] = in_index_col1;
    assign push_flat[IDX_LO + IDX_W +: IDX_W] = in_index_col2;

    // Split the head beat back into per-sample views for the output mux.
    for (genvar gi = 0; gi < SAMPLES; gi++) begin : g_unpack
        assign samp_r[gi] = head_flat[(2*gi)*DATA_W   +: DATA_W];
        assign samp_i[gi] = head_flat[(2*gi+1)*DATA_W +: DATA_W];
    end
    assign head_idx1 = head_flat[IDX_LO         +: IDX_W];
    assign head_idx2 = head_flat[IDX_LO + IDX_W +: IDX_W];

    // A full FIFO still takes a beat when its head beat retires this cycle.
    assign xfer      = out_valid & out_ready;
    assign last_xfer = xfer & (cnt_reg == 3'd7);
    assign push      = in_valid & (~fifo_full | last_xfer);
    assign drop      = in_valid & ~push;

    beat_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_beat_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_flat),
        .pop       (last_xfer),
        .head_data (head_flat),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and out_valid. Leaving IDLE on the push itself gives the
    // one-cycle in_valid to out_valid latency from an empty FIFO.
    always_comb begin
        state_next = state_reg;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (push || !fifo_empty) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                if (last_xfer && (fifo_level == LW'(1)) && !push) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sample counter within the head beat; the 7->0 wrap coincides with the pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (xfer) begin
            cnt_reg <= cnt_reg + 3'd1;
        end
    end

    // Sticky drop flag; a drop in the same cycle beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (clr_ovf) begin
            overflow_reg <= 1'b0;
        end
    end

    // Output mux: head beat and counter are frozen while stalled, so outputs
    // hold. Forced to zero when idle so reset leaves them at 0 regardless of
    // the unreset storage contents.
    assign stream    = (state_reg == STREAM);
    assign out_r     = stream ? samp_r[cnt_reg] : '0;
    assign out_i     = stream ? samp_i[cnt_reg] : '0;
    assign out_index = stream ? (cnt_reg[2] ? head_idx2 : head_idx1) : '0;
    assign out_col   = stream & cnt_reg[2];
    assign out_lane  = stream ? cnt_reg[1:0] : 2'd0;
    assign level     = fifo_level;
    assign overflow  = overflow_reg;

`ifdef FFT_OUT_STATS_EN
    logic [15:0] beats_in_reg;
    logic [15:0] beats_dropped_reg;

    // Saturating beat statistics; clr_ovf restarts both from the current cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_in_reg      <= '0;
            beats_dropped_reg <= '0;
        end else if (clr_ovf) begin
            beats_in_reg      <= {15'd0, push};
            beats_dropped_reg <= {15'd0, drop};
        end else begin
            if (push && (beats_in_reg != 16'hFFFF)) begin
                beats_in_reg <= beats_in_reg + 16'd1;
            end
            if (drop && (beats_dropped_reg != 16'hFFFF)) begin
                beats_dropped_reg <= beats_dropped_reg + 16'd1;
            end
        end
    end

    assign beats_in      = beats_in_reg;
    assign beats_dropped = beats_dropped_reg;
`endif

endmodule

// File: tb/tb_fft_out_serializer.sv
// Bench for fft_out_serializer: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-of-beats reference model.
module tb_fft_out_serializer;

    localparam int DW    = 32;
    localparam int IW    = 11;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic [3:0][DW-1:0]   in_col1_r = '0;
    logic [3:0][DW-1:0]   in_col1_i = '0;
    logic [3:0][DW-1:0]   in_col2_r = '0;
    logic [3:0][DW-1:0]   in_col2_i = '0;
    logic [IW-1:0]        in_index_col1 = '0;
    logic [IW-1:0]        in_index_col2 = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [DW-1:0]        out_r;
    logic [DW-1:0]        out_i;
    logic [IW-1:0]        out_index;
    logic                 out_col;
    logic [1:0]           out_lane;
    logic [LW-1:0]        level;
    logic                 overflow;
    logic                 clr_ovf = 1'b0;
`ifdef FFT_OUT_STATS_EN
    logic [15:0]          beats_in;
    logic [15:0]          beats_dropped;
`endif

    always #5 clk = ~clk;

    fft_out_serializer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_col1_r     (in_col1_r),
        .in_col1_i     (in_col1_i),
        .in_col2_r     (in_col2_r),
        .in_col2_i     (in_col2_i),
        .in_index_col1 (in_index_col1),
        .in_index_col2 (in_index_col2),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_r         (out_r),
        .out_i         (out_i),
        .out_index     (out_index),
        .out_col       (out_col),
        .out_lane      (out_lane),
        .level         (level),
        .overflow      (overflow),
        .clr_ovf       (clr_ovf)
`ifdef FFT_OUT_STATS_EN
        ,
        .beats_in      (beats_in),
        .beats_dropped (beats_dropped)
`endif
    );

    // Reference beat: samples 0..3 are col1 lanes, 4..7 col2 lanes.
    typedef struct packed {
        logic [7:0][DW-1:0] r;
        logic [7:0][DW-1:0] i;
        logic [IW-1:0]      idx1;
        logic [IW-1:0]      idx2;
    } mbeat_t;

    mbeat_t mq[$];        // beats held, head first
    int     pos = 0;      // next sample of the head beat
    logic   m_ovf = 1'b0;
    mbeat_t cur_beat;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic mbeat_t rand_beat();
        mbeat_t b;
        for (int k = 0; k < 8; k++) begin
            b.r[k] = $urandom;
            b.i[k] = $urandom;
        end
        b.idx1 = IW'($urandom);
        b.idx2 = IW'($urandom);
        return b;
    endfunction

    task automatic set_beat(input mbeat_t b);
        cur_beat = b;
        for (int l = 0; l < 4; l++) begin
            in_col1_r[l] = b.r[l];
            in_col1_i[l] = b.i[l];
            in_col2_r[l] = b.r[l+4];
            in_col2_i[l] = b.i[l+4];
        end
        in_index_col1 = b.idx1;
        in_index_col2 = b.idx2;
    endtask

    // One clock: compare outputs at the falling edge, then advance the model
    // with the inputs the DUT samples on the rising edge.
    task automatic step();
        mbeat_t hb;
        logic   xfer;
        logic   last;
        logic   acc;
        @(negedge clk);
        if (!rst_n) begin
            mq.delete();
            pos   = 0;
            m_ovf = 1'b0;
        end
        check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        check("level", 64'(level), 64'(mq.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        if (!rst_n) begin
            check("rst_out_r", 64'(out_r), 64'd0);
            check("rst_out_i", 64'(out_i), 64'd0);
            check("rst_out_index", 64'(out_index), 64'd0);
            check("rst_out_col", 64'(out_col), 64'd0);
            check("rst_out_lane", 64'(out_lane), 64'd0);
        end else if (mq.size() > 0) begin
            hb = mq[0];
            check("out_r", 64'(out_r), 64'(hb.r[pos]));
            check("out_i", 64'(out_i), 64'(hb.i[pos]));
            check("out_index", 64'(out_index), 64'((pos < 4) ? hb.idx1 : hb.idx2));
            check("out_col", 64'(out_col), 64'(pos / 4));
            check("out_lane", 64'(out_lane), 64'(pos % 4));
        end
        @(posedge clk);
        if (rst_n) begin
            xfer = (mq.size() > 0) && out_ready;
            last = xfer && (pos == 7);
            acc  = in_valid && ((mq.size() < DEPTH) || last);
            if (xfer) begin
                if (pos == 7) begin
                    pos = 0;
                    void'(mq.pop_front());
                end else begin
                    pos++;
                end
            end
            if (acc) mq.push_back(cur_beat);
            if (in_valid && !acc) m_ovf = 1'b1;
            else if (clr_ovf)     m_ovf = 1'b0;
            if (in_valid)
                $display("beat idx1=%0d idx2=%0d %s level_after=%0d", cur_beat.idx1, cur_beat.idx2,
                         acc ? "accepted" : "dropped", mq.size());
        end
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        mbeat_t b;
        int     rate;

        // Reset state
        set_beat(rand_beat());
        steps(3);
        rst_n = 1'b1;
        steps(2);

        // Single known beat, ready held high
        for (int k = 0; k < 8; k++) begin
            b.r[k] = DW'(k + 1);
            b.i[k] = $urandom;
        end
        b.idx1 = IW'(10);
        b.idx2 = IW'(11);
        set_beat(b);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        steps(10);

        // Backpressure inside a beat
        set_beat(rand_beat());
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            step();
        end

        // Overflow: stalled output, five beats, then drop with clear together
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_beat(rand_beat());
            in_valid = 1'b1;
            step();
        end
        set_beat(rand_beat());
        clr_ovf = 1'b1;
        step();
        in_valid = 1'b0;
        clr_ovf  = 1'b0;
        steps(2);
        out_ready = 1'b1;
        steps(34);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        steps(2);

        // Full FIFO taking a beat on the head's final transfer
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_beat(rand_beat());
            in_valid = 1'b1;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        steps(7);
        set_beat(rand_beat());
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        steps(42);

        // Reset in the middle of a beat, then a fresh beat
        set_beat(rand_beat());
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        steps(2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        set_beat(rand_beat());
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        steps(10);

        // Randomized traffic at several arrival densities
        for (int blk = 0; blk < 6; blk++) begin
            rate = 4 + blk * 3;
            for (int c = 0; c < 500; c++) begin
                set_beat(rand_beat());
                in_valid  = ($urandom_range(0, rate - 1) == 0);
                out_ready = ($urandom_range(0, 9) < 7);
                clr_ovf   = ($urandom_range(0, 39) == 0);
                step();
            end
        end
        in_valid  = 1'b0;
        clr_ovf   = 1'b0;
        out_ready = 1'b1;
        steps(40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
